fmap_stream_source: RTL and testbench
=====================================

Name: fmap_stream_source

Overview:
- Streaming source for the conv datapath: reads a run of feature-map words from a synchronous single-port memory and drives them as a data_out/valid_out stream into the data_in/valid_in port of a conv stage.
- Treats the conv stage's En as backpressure: a word is consumed only in a cycle where valid_out=1 and En=1.
- Absorbs the 1-cycle memory read latency with a one-entry skid register, so no word is lost or duplicated when En toggles.

Parameters:
DATA_WIDTH, 32, width of feature-map words
ADDR_WIDTH, 10, memory address width

Ports:
Clk  input  1  clock, all state updates on rising edge
Rst  input  1  synchronous, active-high reset
start  input  1  begin a transfer; sampled only in IDLE
base_addr  input  ADDR_WIDTH  first memory address, latched on accepted start
length  input  ADDR_WIDTH+1  number of words to stream, latched on accepted start
En  input  1  downstream enable/ready; word consumed when valid_out & En
mem_rd_en  output  1  memory read strobe
mem_addr  output  ADDR_WIDTH  memory read address
mem_data  input  DATA_WIDTH  memory read data, valid the cycle after mem_rd_en
data_out  output  DATA_WIDTH  stream word to conv stage
valid_out  output  1  data_out holds a valid word
busy  output  1  transfer in progress
done  output  1  one-cycle pulse when the last word is consumed

Behaviour:
- Reset (Rst=1 at an edge): state=IDLE; valid_out, busy, done, mem_rd_en = 0; data_out, mem_addr, counters = 0; skid cleared; in-flight read discarded. This applies mid-transfer too; no done pulse is produced.
- States: IDLE, RUN.
- IDLE, start=1, length!=0:
  - latch base_addr and length; issued_cnt=0, consumed_cnt=0; go to RUN; busy=1 from the next cycle.
- IDLE, start=1, length=0: stay IDLE; done=1 for exactly the next cycle; no reads.
- start while RUN: ignored.
- Read issue (combinational, registered memory interface): mem_rd_en=1 iff RUN & issued_cnt<length & En & skid empty.
  - mem_addr = base_addr + issued_cnt, modulo 2^ADDR_WIDTH (wraps silently).
  - issued_cnt increments on every issue.
- Return path: read data arrives one cycle after mem_rd_en. At that edge:
  - if output register empty or being consumed this cycle, load output from skid if skid full, otherwise from mem_data;
  - if skid was loaded into output, returning data goes to skid;
  - if output is full and not consumed, returning data goes to skid.
  - Order is strictly preserved: skid is always older than in-flight data.
- Consumption: valid_out & En at an edge increments consumed_cnt. The output register then takes the next word (skid or returning data), or valid_out drops to 0 if none.
- data_out and valid_out are held stable while En=0.
- Completion: on the edge where consumed_cnt reaches length, go to IDLE. done=1 and busy=0 for the following cycle; valid_out=0.
- Throughput: 1 word/cycle with En held high.
- Latency with En=1 throughout, start in cycle 0:
  - mem_rd_en in cycles 1..N;
  - valid_out in cycles 3..N+2;
  - done in cycle N+3.
- At most one read in flight; skid depth 1. Output register, skid and in-flight never exceed 2 words beyond consumption.
- Simultaneous start and Rst: Rst wins.

Test Plan:
- Reset: Rst high for 2 cycles mid-transfer -> all outputs 0 next cycle; a following start with base=0, length=4 streams mem[0..3] cleanly.
- Basic run: base=0x010, length=5, En=1, mem[a]=a -> mem_addr 0x010..0x014 in cycles 1..5; data_out 0x10..0x14 with valid_out in cycles 3..7; done in cycle 8 only.
- Backpressure: length=8, En low in cycles 4-6 and 9 -> output sequence is exactly mem[0..7], no gaps in value order, no duplicates; data_out stable while En=0; mem_rd_en never high while skid full.
- Address wrap: ADDR_WIDTH=10, base=0x3FE, length=4 -> addresses 0x3FE, 0x3FF, 0x000, 0x001.
- Zero length and ignored start: length=0 -> done pulse the next cycle, mem_rd_en stays 0. Start pulsed mid-run -> the current transfer is unaffected.
- Full length: length=1024 with random En (50% duty) -> 1024 words consumed in order, a single done pulse, busy deasserted afterwards.

Source files
------------

// File: rtl/fmap_stream_source.sv
// rtl/fmap_stream_source.sv - feature-map memory reader driving a backpressured word stream
module fmap_stream_source #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic                  En,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  busy,
  output logic                  done
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH:0]   len_q;
  logic [ADDR_WIDTH:0]   issued_cnt;
  logic [ADDR_WIDTH:0]   consumed_cnt;
  logic [ADDR_WIDTH:0]   consumed_nxt;
  logic                  rd_pending;
  logic                  skid_valid;
  logic [DATA_WIDTH-1:0] skid_data;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  done_q;
  logic                  consume;
  logic                  last_consume;
  logic                  out_free;

  // Decode consumption, completion and the read strobe; a read is only issued when
  // the word it returns is guaranteed a slot (En high and skid empty)
  always_comb begin
    consume      = out_valid & En;
    consumed_nxt = consumed_cnt + CNT_ONE;
    last_consume = consume && (consumed_nxt == len_q);
    out_free     = !out_valid || consume;
    mem_rd_en    = (state == ST_RUN) && (issued_cnt < len_q) && En && !skid_valid;
    mem_addr     = base_q + issued_cnt[ADDR_WIDTH-1:0];
  end

  // Transfer sequencing: latch the request, count issued and consumed words, flag completion
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state        <= ST_IDLE;
      base_q       <= '0;
      len_q        <= '0;
      issued_cnt   <= '0;
      consumed_cnt <= '0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (length != '0) begin
              state        <= ST_RUN;
              base_q       <= base_addr;
              len_q        <= length;
              issued_cnt   <= '0;
              consumed_cnt <= '0;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (mem_rd_en) issued_cnt <= issued_cnt + CNT_ONE;
          if (consume) consumed_cnt <= consumed_nxt;
          if (last_consume) begin
            state  <= ST_IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Track the single outstanding read; its data is on mem_data the following cycle
  always_ff @(posedge Clk) begin
    if (Rst) rd_pending <= 1'b0;
    else     rd_pending <= mem_rd_en;
  end

  // Output register plus one-entry skid: skid always holds the older word, so order is kept
  always_ff @(posedge Clk) begin
    if (Rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (last_consume) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (rd_pending) begin
      if (out_free) begin
        out_valid <= 1'b1;
        if (skid_valid) begin
          out_data  <= skid_data;
          skid_data <= mem_data;
        end else begin
          out_data <= mem_data;
        end
      end else begin
        skid_data  <= mem_data;
        skid_valid <= 1'b1;
      end
    end else if (out_free) begin
      if (skid_valid) begin
        out_data   <= skid_data;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  assign data_out  = out_data;
  assign valid_out = out_valid;
  assign busy      = (state == ST_RUN);
  assign done      = done_q;

endmodule

// File: tb/tb_fmap_stream_source.sv
// tb/tb_fmap_stream_source.sv - scoreboard bench for fmap_stream_source
`timescale 1ns/1ps
module tb_fmap_stream_source;
  localparam int DW = 32;
  localparam int AW = 10;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          start;
  logic          En;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          busy;
  logic          done;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int n_checks   = 0;
  int n_fail     = 0;
  int issued_n   = 0;
  int consumed_n = 0;

  logic [AW-1:0] exp_addr_q[$];
  logic [DW-1:0] exp_data_q[$];

  bit            stall_prev = 1'b0;
  logic [DW-1:0] held;

  always #5 Clk = ~Clk;

  fmap_stream_source #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .En        (En),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .data_out  (data_out),
    .valid_out (valid_out),
    .busy      (busy),
    .done      (done)
  );

  // synchronous single-port memory model, one cycle read latency
  always @(posedge Clk) if (mem_rd_en) mem_data <= mem[mem_addr];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [AW-1:0] base, input logic [AW:0] len);
    logic [AW-1:0] a;
    a = base;
    for (int i = 0; i < int'(len); i++) begin
      exp_addr_q.push_back(a);
      exp_data_q.push_back(mem[a]);
      a = a + 1'b1;
    end
  endtask

  // stream monitor: pops the scoreboard on every read and every consumed word
  always @(negedge Clk) begin
    if (Rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", valid_out, 1);
        check("hold_data", data_out, held);
      end
      if (valid_out && En) begin
        consumed_n++;
        if (exp_data_q.size() == 0) check("word_unexpected", 1, 0);
        else check("word_data", data_out, exp_data_q.pop_front());
      end
      if (mem_rd_en) begin
        issued_n++;
        check("rd_bound", (issued_n - consumed_n <= 2), 1);
        if (exp_addr_q.size() == 0) check("rd_unexpected", 1, 0);
        else check("rd_addr", mem_addr, exp_addr_q.pop_front());
      end
      stall_prev = valid_out && !En;
      held       = data_out;
    end
  end

  // mode 0: En high, cycle-exact; 1: fixed En gaps; 2: random En; 3: start pulsed mid-run
  task automatic run_xfer(input logic [AW-1:0] base, input logic [AW:0] len, input int mode, input int budget);
    int c;
    int l;
    bit seen;
    c    = 0;
    l    = int'(len);
    seen = 1'b0;
    exp_addr_q.delete();
    exp_data_q.delete();
    issued_n   = 0;
    consumed_n = 0;
    push_exp(base, len);
    @(posedge Clk); #1;
    start = 1'b1; base_addr = base; length = len; En = 1'b1;
    @(negedge Clk);
    check("c0_busy", busy, 0);
    check("c0_rd_en", mem_rd_en, 0);
    while (!seen && c < budget) begin
      @(posedge Clk); #1;
      c++;
      start = 1'b0;
      if (mode == 3 && c == 3) begin
        start = 1'b1; base_addr = 10'h200; length = 11'd7;
      end
      case (mode)
        1:       En = !(c inside {4, 5, 6, 9});
        2:       En = 1'($urandom_range(0, 1));
        default: En = 1'b1;
      endcase
      @(negedge Clk);
      if (mode == 0) begin
        check("x_rd_en", mem_rd_en, (c >= 1 && c <= l));
        check("x_valid", valid_out, (c >= 3 && c <= l + 2));
        check("x_done", done, (c == l + 3));
        check("x_busy", busy, (c >= 1 && c <= l + 2));
      end
      if (done) seen = 1'b1;
    end
    check("done_seen", seen, 1);
    check("words_consumed", consumed_n, l);
    check("reads_issued", issued_n, l);
    check("addr_q_drained", exp_addr_q.size(), 0);
    check("data_q_drained", exp_data_q.size(), 0);
    check("done_busy", busy, 0);
    check("done_valid", valid_out, 0);
    En = 1'b1;
    @(posedge Clk); #1;
    @(negedge Clk);
    check("done_single", done, 0);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i);
    Rst = 1'b1; start = 1'b0; En = 1'b1; base_addr = '0; length = '0;
    repeat (2) @(posedge Clk);
    #1;
    @(negedge Clk);
    check("rst_valid", valid_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", mem_rd_en, 0);
    check("rst_data", data_out, 0);
    check("rst_addr", mem_addr, 0);
    @(posedge Clk); #1;
    Rst = 1'b0;

    run_xfer(10'h010, 11'd5, 0, 40);
    run_xfer(10'h000, 11'd8, 1, 60);
    run_xfer(10'h3FE, 11'd4, 0, 40);

    // zero length: immediate done pulse, no reads
    exp_addr_q.delete();
    exp_data_q.delete();
    @(posedge Clk); #1;
    start = 1'b1; base_addr = 10'h055; length = 11'd0;
    @(posedge Clk); #1;
    start = 1'b0;
    @(negedge Clk);
    check("zl_done", done, 1);
    check("zl_busy", busy, 0);
    check("zl_rd_en", mem_rd_en, 0);
    @(posedge Clk); #1;
    @(negedge Clk);
    check("zl_done_drop", done, 0);

    run_xfer(10'h040, 11'd10, 3, 60);

    // reset in the middle of a transfer, with start asserted on the last reset edge
    exp_addr_q.delete();
    exp_data_q.delete();
    issued_n = 0; consumed_n = 0;
    push_exp(10'h100, 11'd20);
    @(posedge Clk); #1;
    start = 1'b1; base_addr = 10'h100; length = 11'd20; En = 1'b1;
    repeat (5) begin
      @(posedge Clk); #1;
      start = 1'b0;
    end
    Rst = 1'b1;
    @(posedge Clk); #1;
    start = 1'b1; base_addr = 10'h000; length = 11'd4;
    @(posedge Clk); #1;
    Rst = 1'b0; start = 1'b0;
    @(negedge Clk);
    check("mid_rst_valid", valid_out, 0);
    check("mid_rst_data", data_out, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_rd_en", mem_rd_en, 0);
    check("mid_rst_addr", mem_addr, 0);

    run_xfer(10'h000, 11'd4, 0, 40);
    run_xfer(10'h000, 11'd1024, 2, 8000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
